lot_occupancy_tracker: RTL and testbench

//  Downstream of the beam-sequence FSM: consumes its enter/exit event strobes and keeps the lot's car count.

---
 rtl/lot_occupancy_tracker_if.sv | 62 ++++++
 rtl/lot_occupancy_tracker.sv | 195 +++++++++++++++++++
 tb/tb_lot_occupancy_tracker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lot_occupancy_tracker_if.sv
// -----------------------------------------------------------------------------
// lot_occupancy_tracker_if
//   Bundles the event/control inputs and the status outputs of the parking-lot
//   occupancy tracker so producer and consumer share one port.
//
//   Signals
//     enter, exit     car event strobes from the beam-sequence FSM (level, any length)
//     load, load_val  operator preset of the occupancy count
//     clr_err         clears the sticky error flags
//     count           current occupancy
//     empty, near_full, full, gate_closed, ovf_err, unf_err   status flags
//
//   Modports
//     master : drives enter/exit/load/load_val/clr_err, observes status
//     slave  : the tracker itself
// -----------------------------------------------------------------------------
interface lot_occupancy_tracker_if #(
    parameter int CNT_W = 4
);
    logic             enter;
    logic             exit;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             clr_err;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             near_full;
    logic             full;
    logic             gate_closed;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output enter,
        output exit,
        output load,
        output load_val,
        output clr_err,
        input  count,
        input  empty,
        input  near_full,
        input  full,
        input  gate_closed,
        input  ovf_err,
        input  unf_err
    );

    modport slave (
        input  enter,
        input  exit,
        input  load,
        input  load_val,
        input  clr_err,
        output count,
        output empty,
        output near_full,
        output full,
        output gate_closed,
        output ovf_err,
        output unf_err
    );
endinterface

// File: rtl/lot_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// lot_occupancy_tracker
//   Keeps the car count of a parking lot from enter/exit strobes produced by
//   the beam-sequence FSM. Strobes are double-registered and rising-edge
//   detected so each strobe counts once regardless of its length. The count
//   saturates at CAPACITY and at zero; attempts past either limit set sticky
//   error flags. A hysteresis gate FSM drives the "LOT FULL" sign / barrier:
//   it closes at CAPACITY and reopens only once the count falls to REOPEN.
//
//   Ports
//     clk  : clock, all state on rising edge
//     rst  : asynchronous active-low reset
//     bus  : lot_occupancy_tracker_if.slave (events, preset, status)
//
//   Parameters
//     CNT_W     count width (CAPACITY <= 2**CNT_W-1)
//     CAPACITY  saturation limit of the count
//     NEAR_FULL near_full threshold (count >= NEAR_FULL)
//     REOPEN    gate reopen threshold (count <= REOPEN), below CAPACITY
// -----------------------------------------------------------------------------
module lot_occupancy_tracker #(
    parameter int CNT_W     = 4,
    parameter int CAPACITY  = 10,
    parameter int NEAR_FULL = 8,
    parameter int REOPEN    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    lot_occupancy_tracker_if.slave       bus
);

    // Thresholds expressed in count width so every compare is same-width.
    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] NEAR_V   = CNT_W'(NEAR_FULL);
    localparam logic [CNT_W-1:0] REOPEN_V = CNT_W'(REOPEN);
    localparam logic [CNT_W-1:0] ZERO_V   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

    typedef enum logic {
        GATE_OPEN   = 1'b0,
        GATE_CLOSED = 1'b1
    } gate_state_t;

    // Preset values larger than the lot are pulled back to CAPACITY.
    function automatic logic [CNT_W-1:0] clamp_to_cap(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val > CAP_V) begin
            res = CAP_V;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             enter_q_r;
    logic             enter_qq_r;
    logic             exit_q_r;
    logic             exit_qq_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_err_r;
    logic             unf_err_r;
    gate_state_t      gate_state_r;

    // -------------------------------------------------------------------------
    // Combinational next-state
    // -------------------------------------------------------------------------
    logic             ev_in_s;
    logic             ev_out_s;
    logic [CNT_W-1:0] count_next_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             ovf_err_next_s;
    logic             unf_err_next_s;
    gate_state_t      gate_state_next_s;

    // The first register stage also absorbs glitches on the combinational
    // strobes; the edge detect then yields one event per rising edge.
    assign ev_in_s  = enter_q_r & ~enter_qq_r;
    assign ev_out_s = exit_q_r  & ~exit_qq_r;

    // Strobe synchronisation and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enter_q_r  <= 1'b0;
            enter_qq_r <= 1'b0;
            exit_q_r   <= 1'b0;
            exit_qq_r  <= 1'b0;
        end else begin
            enter_q_r  <= bus.enter;
            enter_qq_r <= enter_q_r;
            exit_q_r   <= bus.exit;
            exit_qq_r  <= exit_q_r;
        end
    end

    // Count update with priority load > simultaneous events > enter > exit.
    always_comb begin
        count_next_s = count_r;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        if (bus.load) begin
            // Operator correction overrides any event seen this cycle.
            count_next_s = clamp_to_cap(bus.load_val);
        end else if (ev_in_s && ev_out_s) begin
            // One car in and one out: net zero, even at the limits.
            count_next_s = count_r;
        end else if (ev_in_s) begin
            if (count_r < CAP_V) begin
                count_next_s = count_r + ONE_V;
            end else begin
                count_next_s = count_r;
                ovf_set_s    = 1'b1;
            end
        end else if (ev_out_s) begin
            if (count_r > ZERO_V) begin
                count_next_s = count_r - ONE_V;
            end else begin
                count_next_s = count_r;
                unf_set_s    = 1'b1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Sticky error flags: a new error in the clearing cycle keeps the flag set.
    always_comb begin
        ovf_err_next_s = ovf_set_s | (ovf_err_r & ~bus.clr_err);
        unf_err_next_s = unf_set_s | (unf_err_r & ~bus.clr_err);
    end

    // Occupancy count and error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= ZERO_V;
            ovf_err_r <= 1'b0;
            unf_err_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            ovf_err_r <= ovf_err_next_s;
            unf_err_r <= unf_err_next_s;
        end
    end

    // Gate hysteresis: looks at the already-updated count, so it trails the
    // count by one cycle. The gap between REOPEN and CAPACITY stops the sign
    // flickering when cars enter and leave around the full mark.
    always_comb begin
        gate_state_next_s = gate_state_r;
        case (gate_state_r)
            GATE_OPEN: begin
                if (count_r == CAP_V) begin
                    gate_state_next_s = GATE_CLOSED;
                end else begin
                    gate_state_next_s = GATE_OPEN;
                end
            end
            GATE_CLOSED: begin
                if (count_r <= REOPEN_V) begin
                    gate_state_next_s = GATE_OPEN;
                end else begin
                    gate_state_next_s = GATE_CLOSED;
                end
            end
            default: begin
                gate_state_next_s = GATE_OPEN;
            end
        endcase
    end

    // Gate state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_state_r <= GATE_OPEN;
        end else begin
            gate_state_r <= gate_state_next_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: count and errors straight from registers, level flags decoded
    // from the registered count so they move in the same cycle as count.
    // -------------------------------------------------------------------------
    assign bus.count       = count_r;
    assign bus.empty       = (count_r == ZERO_V);
    assign bus.near_full   = (count_r >= NEAR_V);
    assign bus.full        = (count_r == CAP_V);
    assign bus.gate_closed = (gate_state_r == GATE_CLOSED);
    assign bus.ovf_err     = ovf_err_r;
    assign bus.unf_err     = unf_err_r;

endmodule

// File: tb/tb_lot_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// tb_lot_occupancy_tracker
//   Directed bench for lot_occupancy_tracker (CAPACITY 10, NEAR_FULL 8,
//   REOPEN 8). Inputs change 1 time unit after a rising edge, outputs are
//   sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_lot_occupancy_tracker;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    lot_occupancy_tracker_if #(.CNT_W(CNT_W)) bus_if ();

    lot_occupancy_tracker #(
        .CNT_W    (CNT_W),
        .CAPACITY (10),
        .NEAR_FULL(8),
        .REOPEN   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; the count reflects it after the second edge.
    task automatic pulse_enter();
        bus_if.enter = 1'b1;
        step();
        bus_if.enter = 1'b0;
        step();
    endtask

    task automatic pulse_exit();
        bus_if.exit = 1'b1;
        step();
        bus_if.exit = 1'b0;
        step();
    endtask

    task automatic load_count(input logic [CNT_W-1:0] val);
        bus_if.load     = 1'b1;
        bus_if.load_val = val;
        step();
        bus_if.load     = 1'b0;
        bus_if.load_val = 4'd0;
    endtask

    task automatic clr_pulse();
        bus_if.clr_err = 1'b1;
        step();
        bus_if.clr_err = 1'b0;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b0;
        bus_if.enter    = 1'b0;
        bus_if.exit     = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.load_val = 4'd0;
        bus_if.clr_err  = 1'b0;

        // ---- reset state ----
        #3;
        check_eq("rst_count", bus_if.count, 0);
        check_eq("rst_empty", bus_if.empty, 1);
        check_eq("rst_near", bus_if.near_full, 0);
        check_eq("rst_full", bus_if.full, 0);
        check_eq("rst_gate", bus_if.gate_closed, 0);
        check_eq("rst_ovf", bus_if.ovf_err, 0);
        check_eq("rst_unf", bus_if.unf_err, 0);
        step();
        rst = 1'b1;
        step();

        // ---- 1: single strobe, two-edge latency ----
        bus_if.enter = 1'b1;
        step();
        check_eq("t1_count_edge1", bus_if.count, 0);
        bus_if.enter = 1'b0;
        step();
        check_eq("t1_count_edge2", bus_if.count, 1);
        check_eq("t1_empty", bus_if.empty, 0);
        check_eq("t1_ovf", bus_if.ovf_err, 0);
        check_eq("t1_unf", bus_if.unf_err, 0);

        // ---- 2: held strobe counts once; saturation at 10 ----
        bus_if.enter = 1'b1;
        repeat (5) step();
        bus_if.enter = 1'b0;
        step();
        check_eq("t2_held_count", bus_if.count, 2);
        repeat (8) pulse_enter();
        check_eq("t2_count10", bus_if.count, 10);
        check_eq("t2_full", bus_if.full, 1);
        check_eq("t2_near", bus_if.near_full, 1);
        check_eq("t2_ovf_clean", bus_if.ovf_err, 0);
        check_eq("t2_gate_lag", bus_if.gate_closed, 0);
        step();
        check_eq("t2_gate_closed", bus_if.gate_closed, 1);
        repeat (2) pulse_enter();
        check_eq("t2_sat_count", bus_if.count, 10);
        check_eq("t2_ovf_set", bus_if.ovf_err, 1);

        // ---- 3: hysteresis on the way down ----
        pulse_exit();
        check_eq("t3_count9", bus_if.count, 9);
        step();
        check_eq("t3_gate_at9", bus_if.gate_closed, 1);
        pulse_exit();
        check_eq("t3_count8", bus_if.count, 8);
        check_eq("t3_near8", bus_if.near_full, 1);
        check_eq("t3_gate_lag8", bus_if.gate_closed, 1);
        step();
        check_eq("t3_gate_open8", bus_if.gate_closed, 0);
        pulse_exit();
        check_eq("t3_count7", bus_if.count, 7);
        check_eq("t3_near7", bus_if.near_full, 0);
        clr_pulse();
        check_eq("t3_ovf_clr", bus_if.ovf_err, 0);

        // ---- 4: underflow and sticky clearing ----
        load_count(4'd0);
        check_eq("t4_load0", bus_if.count, 0);
        check_eq("t4_empty", bus_if.empty, 1);
        pulse_exit();
        check_eq("t4_unf_count", bus_if.count, 0);
        check_eq("t4_unf_set", bus_if.unf_err, 1);
        clr_pulse();
        check_eq("t4_unf_clr", bus_if.unf_err, 0);
        bus_if.exit = 1'b1;
        step();
        bus_if.exit    = 1'b0;
        bus_if.clr_err = 1'b1;
        step();
        bus_if.clr_err = 1'b0;
        check_eq("t4_set_wins", bus_if.unf_err, 1);
        clr_pulse();
        check_eq("t4_unf_clr2", bus_if.unf_err, 0);

        // ---- 5: simultaneous enter/exit at the limits ----
        bus_if.enter = 1'b1;
        bus_if.exit  = 1'b1;
        step();
        bus_if.enter = 1'b0;
        bus_if.exit  = 1'b0;
        step();
        check_eq("t5_cnt0", bus_if.count, 0);
        check_eq("t5_unf0", bus_if.unf_err, 0);
        check_eq("t5_ovf0", bus_if.ovf_err, 0);
        load_count(4'd10);
        bus_if.enter = 1'b1;
        bus_if.exit  = 1'b1;
        step();
        bus_if.enter = 1'b0;
        bus_if.exit  = 1'b0;
        step();
        check_eq("t5_cnt10", bus_if.count, 10);
        check_eq("t5_ovf10", bus_if.ovf_err, 0);
        check_eq("t5_unf10", bus_if.unf_err, 0);

        // ---- 6: clamped load beats a concurrent enter event ----
        load_count(4'd5);
        step();
        step();
        check_eq("t6_cnt5", bus_if.count, 5);
        check_eq("t6_gate_open", bus_if.gate_closed, 0);
        bus_if.enter = 1'b1;
        step();
        bus_if.load     = 1'b1;
        bus_if.load_val = 4'd15;
        step();
        bus_if.load     = 1'b0;
        bus_if.load_val = 4'd0;
        bus_if.enter    = 1'b0;
        check_eq("t6_clamp", bus_if.count, 10);
        check_eq("t6_full", bus_if.full, 1);
        check_eq("t6_no_ovf", bus_if.ovf_err, 0);
        check_eq("t6_gate_lag", bus_if.gate_closed, 0);
        step();
        check_eq("t6_gate_closed", bus_if.gate_closed, 1);
        check_eq("t6_no_ovf2", bus_if.ovf_err, 0);

        // ---- 6b: asynchronous reset during a strobe ----
        bus_if.enter = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_arst_count", bus_if.count, 0);
        check_eq("t6_arst_empty", bus_if.empty, 1);
        check_eq("t6_arst_full", bus_if.full, 0);
        check_eq("t6_arst_gate", bus_if.gate_closed, 0);
        check_eq("t6_arst_near", bus_if.near_full, 0);
        step();
        rst = 1'b1;
        step();
        step();
        check_eq("t6_post_rst_event", bus_if.count, 1);
        bus_if.enter = 1'b0;
        repeat (3) step();
        check_eq("t6_post_rst_once", bus_if.count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
